regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised, clocked successor to the decode-stage register file: NUM_RD combinational read ports, one synchronous write port from WB, and x0 hard-wired to zero.
- Adds a per-register busy scoreboard: set when decode issues an instruction writing rd, cleared at WB or by flush.
- Read ports return data plus a busy flag, so hazard/stall logic in decode can gate issue.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), register address width; derived, not overridden.
- NUM_RD, 2, number of read ports; range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, active-low.
- rd_addr  in  NUM_RD x AW  read addresses (port 0 = rs1, port 1 = rs2, ...).
- rd_en  in  NUM_RD  per-port read enable.
- rd_data  out  NUM_RD x XLEN  read data.
- rd_busy  out  NUM_RD  the addressed register has a pending write.
- wr_en  in  1  WB write enable.
- wr_addr  in  AW  WB destination register.
- wr_data  in  XLEN  WB data.
- iss_en  in  1  decode issued an instruction that writes iss_addr.
- iss_addr  in  AW  issued destination register.
- flush  in  1  synchronous clear of all busy bits; register contents are unaffected.
- busy_vec  out  NREGS  full scoreboard, for debug and hazard logic.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n = 0, asynchronous):
  - All registers are 0 and all busy bits are 0.
  - Outputs therefore read 0: rd_data = 0, rd_busy = 0, busy_vec = 0.
  - State holds while rst_n stays low.
  - Release is synchronous to clk; the first write can take effect on the first rising edge after rst_n goes high.
- Write:
  - On a rising edge with wr_en = 1 and wr_addr != 0, regs[wr_addr] <= wr_data.
  - Writes to x0 are discarded.
  - Write latency is 1 cycle (see the optional feature for same-cycle visibility).
- Read (combinational, zero latency):
  - rd_data[i] = 0 if rd_en[i] = 0 or rd_addr[i] = 0; otherwise regs[rd_addr[i]].
  - rd_busy[i] = rd_en[i] and (rd_addr[i] != 0) and busy[rd_addr[i]].
  - Several ports may read the same address simultaneously.
- Scoreboard, per register r, evaluated at each rising edge:
  - flush = 1: busy[r] <= 0. Flush has priority over everything.
  - Otherwise, if iss_en = 1 and iss_addr = r with r != 0: busy[r] <= 1. Set wins over a same-cycle clear, because the new issue supersedes the retiring writer.
  - Otherwise, if wr_en = 1 and wr_addr = r: busy[r] <= 0.
  - Otherwise busy[r] holds.
  - busy[0] is constantly 0.
  - Only a single outstanding writer per register is tracked; decode must not issue a second writer to a busy register. This rule is an assertion target and is not enforced in RTL.
- WB write to a non-busy register: data is written and busy stays 0 (no error).
- Flush and wr_en in the same cycle: the write still commits to the register and all busy bits clear.
- rd_busy is computed from the registered scoreboard state and does not reflect a same-cycle iss_en.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If wr_en = 1, wr_addr != 0, rd_en[i] = 1 and rd_addr[i] = wr_addr, then rd_data[i] = wr_data in the same cycle.
  - rd_busy[i] is forced to 0 in that cycle unless iss_en targets the same register.
  - Only the read path gains logic (forwarding muxes); register storage is unchanged.
- Not defined:
  - No forwarding; rd_data[i] returns the old value until the cycle after the write.
  - rd_busy[i] follows the registered busy bit only.

Decomposition:
- Package regfile_pkg holds:
  - constants XLEN_DEF = 32, NREGS_DEF = 32;
  - typedefs reg_addr_t (logic [4:0]) and xlen_t (logic [31:0]);
  - localparam REG_ZERO = 0.
- Sub-module regfile_sb_bits (params NREGS, AW):
  - inputs clk, rst_n, iss_en, iss_addr, wr_en, wr_addr, flush;
  - output busy_vec;
  - contains the scoreboard only, so it can be reused by the future FP register file.
- Storage array and read muxes stay in the top module.

Test Plan:
- Reset: assert rst_n = 0 mid-run after writing x5 = 0xDEADBEEF -> rd_data = 0 and busy_vec = 0 immediately, before any clock edge. After release, reading x5 returns 0.
- Write/read and x0: write x0 = 0xFFFFFFFF, then x31 = 0x12345678 -> reading x0 returns 0; reading x31 returns 0x12345678 one cycle later. With rd_en = 0 on a port, that port returns 0.
- Scoreboard: iss_en with iss_addr = 7 -> next cycle busy_vec[7] = 1 and rd_busy = 1 when reading x7. A WB write of x7 = 0xA5 clears busy_vec[7] the following cycle. Any iss_en to x0 leaves busy_vec[0] = 0.
- Simultaneous set/clear: busy[3] = 1, then in one cycle wr_en with wr_addr = 3 and iss_en with iss_addr = 3 -> busy[3] stays 1 and x3 holds the new data.
- Flush: busy set on x2, x9 and x20; assert flush together with wr_en to x9 = 0x55 -> busy_vec = 0 next cycle and x9 = 0x55.
- Bypass: read x4 on port 1 while writing x4 = 0xCAFEF00D -> with REGFILE_BYPASS_EN, port 1 returns 0xCAFEF00D in the same cycle; without it, the old value that cycle and the new value the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the integer register file and its scoreboard.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   reg_addr_t / xlen_t  : address and data types for the default configuration
//   REG_ZERO             : index of the hard-wired zero register (x0)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xlen_t;

    localparam int REG_ZERO = 0;

endpackage : regfile_pkg

// File: rtl/regfile_sb_bits.sv
// -----------------------------------------------------------------------------
// regfile_sb_bits
// Per-register busy scoreboard. Kept apart from the storage so the FP register
// file can reuse it unchanged.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   iss_en, iss_addr   : decode issued a writer of iss_addr -> set busy
//   wr_en,  wr_addr    : writeback retires a writer of wr_addr -> clear busy
//   flush              : clear every busy bit
//   busy_vec [NREGS]   : registered scoreboard state (bit 0 always 0)
//
// Update priority at each rising edge: flush, then set from issue, then clear
// from writeback. A same-cycle issue beats a retire to the same register since
// the new writer supersedes the one retiring.
// -----------------------------------------------------------------------------
module regfile_sb_bits
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            // Clear first, then set, so a same-cycle issue wins.
            if (wr_en) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (iss_en) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
        // x0 never has a pending writer.
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule : regfile_sb_bits

// File: rtl/regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb
// Multi-port register file with a busy scoreboard: NUM_RD combinational read
// ports, one synchronous writeback port, x0 hard-wired to zero.
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   rd_addr [NUM_RD][AW]        : read addresses (port 0 = rs1, port 1 = rs2)
//   rd_en   [NUM_RD]            : per-port read enable; disabled port reads 0
//   rd_data [NUM_RD][XLEN]      : read data
//   rd_busy [NUM_RD]            : addressed register has a pending writer
//   wr_en, wr_addr, wr_data     : writeback port (writes to x0 dropped)
//   iss_en, iss_addr            : decode issued a writer of iss_addr
//   flush                       : clear all busy bits (contents untouched)
//   busy_vec [NREGS]            : full scoreboard, for debug and hazard logic
//
// Interface timing: there is no valid/ready handshake. Reads are purely
// combinational and valid whenever rd_en is high; writeback, issue and flush
// are single-cycle strobes sampled on the rising edge and always accepted.
// rd_busy reflects registered scoreboard state only, never a same-cycle issue.
//
// Build option: define REGFILE_BYPASS_EN to forward wr_data to a read port that
// addresses the register being written in the same cycle.
// -----------------------------------------------------------------------------
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NUM_RD = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_RD-1:0][AW-1:0]     rd_addr,
    input  logic [NUM_RD-1:0]             rd_en,
    output logic [NUM_RD-1:0][XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]             rd_busy,
    input  logic                          wr_en,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [XLEN-1:0]               wr_data,
    input  logic                          iss_en,
    input  logic [AW-1:0]                 iss_addr,
    input  logic                          flush,
    output logic [NREGS-1:0]              busy_vec
);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    regfile_sb_bits #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb_bits (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i] = '0;
            rd_busy[i] = 1'b0;
            if (rd_en[i] && (rd_addr[i] != '0)) begin
                rd_data[i] = regs_q[rd_addr[i]];
                rd_busy[i] = busy_vec[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
                // The retiring value is already on wr_data, so the reader
                // sees it now and the pending writer counts as done -- unless
                // decode is issuing a fresh writer of the same register.
                if (wr_en && (wr_addr == rd_addr[i])) begin
                    rd_data[i] = wr_data;
                    if (!(iss_en && (iss_addr == rd_addr[i]))) begin
                        rd_busy[i] = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule : regfile_mp_sb

// File: tb/tb_regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp_sb
// Bench for regfile_mp_sb (default parameters). A driver applies one stimulus
// vector per cycle at the falling edge and pushes the expected read-port and
// scoreboard values, taken from a plain array model, into queues; a monitor
// samples the DUT shortly afterwards and pops/compares. Directed scenarios are
// followed by randomized traffic. Follows REGFILE_BYPASS_EN when defined.
// -----------------------------------------------------------------------------
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int AW     = 5;
    localparam int NUM_RD = 2;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------
    logic [NUM_RD-1:0][AW-1:0]   rd_addr;
    logic [NUM_RD-1:0]           rd_en;
    logic [NUM_RD-1:0][XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]           rd_busy;
    logic                        wr_en;
    logic [AW-1:0]               wr_addr;
    logic [XLEN-1:0]             wr_data;
    logic                        iss_en;
    logic [AW-1:0]               iss_addr;
    logic                        flush;
    logic [NREGS-1:0]            busy_vec;

    regfile_mp_sb #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    // ------------------------------------------------------------------
    // Reference model and scoreboard queues
    // ------------------------------------------------------------------
    xlen_t m_regs [NREGS];
    bit    m_busy [NREGS];

    logic [XLEN:0]    exp_q[$];     // {busy, data}, NUM_RD entries per cycle
    logic [NREGS-1:0] exp_bv_q[$];  // one entry per cycle

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic step(input bit rn, input bit [1:0] en,
                        input reg_addr_t a0, input reg_addr_t a1,
                        input bit we, input reg_addr_t wa, input xlen_t wd,
                        input bit ie, input reg_addr_t ia, input bit fl);
        reg_addr_t        a;
        xlen_t            d;
        bit               b;
        logic [NREGS-1:0] bv;
        @(negedge clk);
        cyc++;
        rst_n      = rn;
        rd_en      = en;
        rd_addr[0] = a0;
        rd_addr[1] = a1;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        iss_en     = ie;
        iss_addr   = ia;
        flush      = fl;

        // Asynchronous reset empties the file immediately.
        if (!rn) begin
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end

        for (int i = 0; i < NUM_RD; i++) begin
            a = (i == 0) ? a0 : a1;
            d = '0;
            b = 1'b0;
            if (en[i] && a != 0) begin
                d = m_regs[a];
                b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
                if (rn && we && wa == a) begin
                    d = wd;
                    if (!(ie && ia == a)) b = 1'b0;
                end
`endif
            end
            exp_q.push_back({b, d});
        end
        for (int r = 0; r < NREGS; r++) bv[r] = m_busy[r];
        exp_bv_q.push_back(bv);

        // State seen after the coming rising edge.
        if (rn) begin
            if (we && wa != 0) m_regs[wa] = wd;
            if (fl) begin
                for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
            end else begin
                if (we) m_busy[wa] = 1'b0;
                if (ie && ia != 0) m_busy[ia] = 1'b1;
            end
        end
    endtask

    task automatic idle_rd(input bit [1:0] en, input reg_addr_t a0, input reg_addr_t a1);
        step(1'b1, en, a0, a1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    initial begin
        logic [XLEN:0]    e;
        logic [NREGS-1:0] bv;
        forever begin
            @(negedge clk);
            #2;
            if (exp_bv_q.size() != 0) begin
                bv = exp_bv_q.pop_front();
                chk("busy_vec", busy_vec, bv);
                for (int i = 0; i < NUM_RD; i++) begin
                    e = exp_q.pop_front();
                    chk($sformatf("rd_data[%0d]", i), rd_data[i], e[XLEN-1:0]);
                    chk($sformatf("rd_busy[%0d]", i), {31'b0, rd_busy[i]}, {31'b0, e[XLEN]});
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n    = 1'b0;
        rd_en    = '0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end

        // Reset state
        step(0, 2'b11, 5, 31, 0, 0, 32'h0, 0, 0, 0);
        step(0, 2'b11, 5, 31, 0, 0, 32'h0, 0, 0, 0);

        // Write x5, then reset mid-run: outputs drop before any edge
        step(1, 2'b01, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        idle_rd(2'b11, 5, 5);
        step(0, 2'b11, 5, 5, 0, 0, 32'h0, 0, 0, 0);
        idle_rd(2'b11, 5, 5);
        idle_rd(2'b11, 5, 5);

        // x0 is never written; x31 visible one cycle later; disabled port reads 0
        step(1, 2'b01, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
        step(1, 2'b11, 0, 31, 1, 31, 32'h12345678, 0, 0, 0);
        idle_rd(2'b10, 31, 31);

        // Scoreboard set by issue, cleared by writeback
        step(1, 2'b11, 7, 7, 0, 0, 32'h0, 1, 7, 0);
        idle_rd(2'b11, 7, 0);
        step(1, 2'b01, 7, 0, 1, 7, 32'h000000A5, 0, 0, 0);
        idle_rd(2'b11, 7, 7);

        // Issue to x0 leaves busy_vec[0] clear
        step(1, 2'b00, 0, 0, 0, 0, 32'h0, 1, 0, 0);
        idle_rd(2'b11, 0, 0);

        // Same-cycle set and clear of x3: set wins, data commits
        step(1, 2'b01, 3, 0, 0, 0, 32'h0, 1, 3, 0);
        step(1, 2'b01, 3, 0, 1, 3, 32'h00000033, 1, 3, 0);
        idle_rd(2'b11, 3, 3);
        step(1, 2'b00, 0, 0, 1, 3, 32'h00000034, 0, 0, 0);

        // Flush together with a writeback to x9
        step(1, 2'b00, 0, 0, 0, 0, 32'h0, 1, 2, 0);
        step(1, 2'b00, 0, 0, 0, 0, 32'h0, 1, 9, 0);
        step(1, 2'b11, 2, 9, 0, 0, 32'h0, 1, 20, 0);
        step(1, 2'b11, 9, 2, 1, 9, 32'h00000055, 0, 0, 1);
        idle_rd(2'b11, 9, 20);

        // Read x4 on port 1 during its writeback
        step(1, 2'b00, 0, 0, 1, 4, 32'h00001111, 0, 0, 0);
        step(1, 2'b10, 0, 4, 1, 4, 32'hCAFEF00D, 0, 0, 0);
        idle_rd(2'b10, 0, 4);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(1'b1,
                 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 31)),
                 $urandom,
                 ($urandom_range(0, 9) < 3),
                 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 19) == 0));
        end

        // Let the monitor drain and make sure every expectation was consumed
        @(negedge clk);
        #5;
        n_cmp++;
        if (exp_q.size() != 0 || exp_bv_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d/%0d entries left expected 0/0",
                     exp_q.size(), exp_bv_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_regfile_mp_sb
